// File: rtl/alu_result_fifo_if.sv
// alu_result_fifo_if
// Bundles the producer-side and consumer-side handshakes of the ALU result
// FIFO.
//   slave  : the FIFO itself. It takes in_* and out_ready, and drives
//            in_ready, out_* and count.
//   master : the environment around the FIFO, which is the ALU side plus
//            the consumer side.
// Parameters:
//   N     : operand MSB index. Operands are N+1 bits and results are N+2 bits.
//   DEPTH : number of FIFO entries.
interface alu_result_fifo_if #(
  parameter int N     = 63,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_opcode;
  logic [N:0]    in_b;
  logic [N+1:0]  in_y;
  logic          out_valid;
  logic          out_ready;
  logic [N+1:0]  out_y;
  logic          out_zero;
  logic          out_carry;
  logic          out_err;
  logic [CW-1:0] count;

  modport slave (
    input  in_valid, in_opcode, in_b, in_y, out_ready,
    output in_ready, out_valid, out_y, out_zero, out_carry, out_err, count
  );

  modport master (
    output in_valid, in_opcode, in_b, in_y, out_ready,
    input  in_ready, out_valid, out_y, out_zero, out_carry, out_err, count
  );
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo
// Result stage that sits after the combinational ALU. Each accepted ALU
// result is stored in a small FIFO together with flags derived from the
// opcode (zero, carry, divide-by-zero). The stored entry is then handed to
// a consumer that may stall, using a valid/ready handshake. The flags are
// computed once, when the entry is written, so the consumer never needs
// the ALU inputs.
//
// Ports:
//   clk   : rising-edge clock.
//   rst_n : asynchronous, active-low reset.
//   bus   : alu_result_fifo_if.slave, which carries:
//           in_valid/in_ready/in_opcode/in_b/in_y   (ALU side)
//           out_valid/out_ready/out_y/out_zero/out_carry/out_err (consumer)
//           count (number of occupied entries)
//
// Optional feature: define ALU_RESULT_DIV0_EN to store divide-by-zero
// results (opcode 4'b0011 or 4'b0100 with in_b == 0) as y = 0, err = 1.
// Without it, out_err is tied to 0 and in_b is ignored.
module alu_result_fifo #(
  parameter int N     = 63,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_result_fifo_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Only add and sub produce a meaningful carry/borrow in bit N+1.
  function automatic logic carry_flag(input logic [3:0] op, input logic msb);
    logic c;
    case (op)
      4'b0000: c = msb;
      4'b0001: c = msb;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

`ifdef ALU_RESULT_DIV0_EN
  // Divide (4'b0011) and modulo (4'b0100) are undefined when the divisor is zero.
  function automatic logic is_div0(input logic [3:0] op, input logic [N:0] b);
    logic d;
    case (op)
      4'b0011: d = (b == {(N+1){1'b0}});
      4'b0100: d = (b == {(N+1){1'b0}});
      default: d = 1'b0;
    endcase
    return d;
  endfunction
`endif

  logic [N+1:0]  mem_y_r [DEPTH];
  logic [DEPTH-1:0] mem_zero_r;
  logic [DEPTH-1:0] mem_carry_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic          in_ready_s;
  logic          out_valid_s;
  logic          push_s;
  logic          pop_s;
  logic [N+1:0]  wr_y_s;
  logic          wr_zero_s;
  logic          wr_carry_s;
  logic          wr_err_s;

  // in_ready is derived from count only, so it never depends on out_ready.
  assign in_ready_s  = (count_r < CW'(DEPTH));
  assign out_valid_s = (count_r != {CW{1'b0}});
  assign push_s      = bus.in_valid && in_ready_s;
  assign pop_s       = out_valid_s && bus.out_ready;

  // Build the entry to be written, including the divide-by-zero substitution.
  always_comb begin
    wr_y_s   = bus.in_y;
    wr_err_s = 1'b0;
`ifdef ALU_RESULT_DIV0_EN
    if (is_div0(bus.in_opcode, bus.in_b)) begin
      wr_y_s   = {(N+2){1'b0}};
      wr_err_s = 1'b1;
    end else begin
      wr_y_s   = bus.in_y;
      wr_err_s = 1'b0;
    end
`endif
    wr_zero_s  = (wr_y_s == {(N+2){1'b0}});
    wr_carry_s = carry_flag(bus.in_opcode, bus.in_y[N+1]);
  end

  // Pointer and occupancy bookkeeping. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage. It is cleared on reset so that the head reads as zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_y_r[i] <= {(N+2){1'b0}};
      end
      mem_zero_r  <= {DEPTH{1'b0}};
      mem_carry_r <= {DEPTH{1'b0}};
    end else if (push_s) begin
      mem_y_r[wr_ptr_r]     <= wr_y_s;
      mem_zero_r[wr_ptr_r]  <= wr_zero_s;
      mem_carry_r[wr_ptr_r] <= wr_carry_s;
    end
  end

`ifdef ALU_RESULT_DIV0_EN
  logic [DEPTH-1:0] mem_err_r;

  // Divide-by-zero flag storage, kept alongside the other entry fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_err_r <= {DEPTH{1'b0}};
    end else if (push_s) begin
      mem_err_r[wr_ptr_r] <= wr_err_s;
    end
  end

  assign bus.out_err = mem_err_r[rd_ptr_r];
`else
  // Without the feature, in_b and the computed err bit have no consumer.
  logic unused_s;
  assign unused_s    = ^{bus.in_b, wr_err_s};
  assign bus.out_err = 1'b0;
`endif

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.count     = count_r;
  assign bus.out_y     = mem_y_r[rd_ptr_r];
  assign bus.out_zero  = mem_zero_r[rd_ptr_r];
  assign bus.out_carry = mem_carry_r[rd_ptr_r];
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo
// Directed and randomized stimulus for alu_result_fifo. It is checked
// against a queue-based reference model of the result FIFO. Outputs are
// sampled 1 time unit after each rising edge.
// Honors ALU_RESULT_DIV0_EN in the same way as the design.
module tb_alu_result_fifo;
  localparam int N     = 63;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef ALU_RESULT_DIV0_EN
  localparam bit DIV0 = 1'b1;
`else
  localparam bit DIV0 = 1'b0;
`endif

  typedef struct packed {
    logic [N+1:0] y;
    logic         zero;
    logic         carry;
    logic         err;
  } entry_t;

  entry_t q[$];
  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  int     n_vec = 0;
  int     n_chk = 0;
  int     n_err = 0;

  always #5 clk = ~clk;

  alu_result_fifo_if #(.N(N), .DEPTH(DEPTH)) bus ();
  alu_result_fifo #(.N(N), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic entry_t model_entry(input logic [3:0] op, input logic [N:0] b,
                                         input logic [N+1:0] y);
    entry_t e;
    e.y   = y;
    e.err = 1'b0;
    if (DIV0 && (op == 4'd3 || op == 4'd4) && b == '0) begin
      e.y   = '0;
      e.err = 1'b1;
    end
    e.zero  = (e.y == '0);
    e.carry = (op == 4'd0 || op == 4'd1) ? y[N+1] : 1'b0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [N+1:0] obs, input logic [N+1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", (N+2)'(bus.in_ready), (N+2)'(q.size() < DEPTH));
    chk("out_valid", (N+2)'(bus.out_valid), (N+2)'(q.size() != 0));
    chk("count", (N+2)'(bus.count), (N+2)'(q.size()));
    if (q.size() != 0) begin
      chk("out_y", bus.out_y, q[0].y);
      chk("out_zero", (N+2)'(bus.out_zero), (N+2)'(q[0].zero));
      chk("out_carry", (N+2)'(bus.out_carry), (N+2)'(q[0].carry));
      chk("out_err", (N+2)'(bus.out_err), (N+2)'(q[0].err));
    end
  endtask

  task automatic check_reset();
    chk("rst_count", (N+2)'(bus.count), '0);
    chk("rst_in_ready", (N+2)'(bus.in_ready), (N+2)'(1));
    chk("rst_out_valid", (N+2)'(bus.out_valid), '0);
    chk("rst_out_y", bus.out_y, '0);
    chk("rst_out_zero", (N+2)'(bus.out_zero), '0);
    chk("rst_out_carry", (N+2)'(bus.out_carry), '0);
    chk("rst_out_err", (N+2)'(bus.out_err), '0);
  endtask

  // One clock of stimulus. The model advances at the edge, then all outputs are checked.
  task automatic step(input logic v, input logic [3:0] op, input logic [N:0] b,
                      input logic [N+1:0] y, input logic r);
    bit push_ok, pop_ok;
    bus.in_valid  = v;
    bus.in_opcode = op;
    bus.in_b      = b;
    bus.in_y      = y;
    bus.out_ready = r;
    n_vec++;
    @(posedge clk);
    push_ok = v && (q.size() < DEPTH);
    pop_ok  = r && (q.size() != 0);
    if (pop_ok)  void'(q.pop_front());
    if (push_ok) q.push_back(model_entry(op, b, y));
    #1;
    check_all();
  endtask

  task automatic drain();
    while (q.size() != 0) step(1'b0, 4'd0, '0, '0, 1'b1);
  endtask

  function automatic logic [N+1:0] rand_y();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[N+1:0];
  endfunction

  initial begin
    logic [N+1:0] y0;
    bus.in_valid  = 1'b0;
    bus.in_opcode = 4'd0;
    bus.in_b      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b0;
    #3;
    check_reset();
    #5 rst_n = 1'b1;

    // First push: carry from add, one-cycle latency.
    y0 = 65'h1_0000_0000_0000_0005;
    step(1'b1, 4'b0000, 64'd1, y0, 1'b0);
    chk("first_carry", (N+2)'(bus.out_carry), (N+2)'(1));
    chk("first_y", bus.out_y, y0);
    drain();

    // Fill past full with the consumer stalled.
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0001, 64'd7, (N+2)'(100 + i), 1'b0);
    chk("full_count", (N+2)'(bus.count), (N+2)'(4));
    chk("full_head", bus.out_y, (N+2)'(100));
    drain();

    // Simultaneous push/pop at count 2 across pointer wrap.
    step(1'b1, 4'b0010, 64'd1, (N+2)'(200), 1'b0);
    step(1'b1, 4'b0010, 64'd1, (N+2)'(201), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 4'b0010, 64'd1, (N+2)'(202 + i), 1'b1);
    chk("wrap_count", (N+2)'(bus.count), (N+2)'(2));
    drain();

    // Divide-by-zero handling, then non-zero divisor.
    step(1'b1, 4'b0011, '0, (N+2)'(5), 1'b0);
    step(1'b1, 4'b0100, '0, (N+2)'(9), 1'b0);
    step(1'b1, 4'b0011, 64'd3, (N+2)'(5), 1'b0);
    drain();

    // No carry outside add/sub, zero flag on an all-zero result, unimplemented opcode.
    step(1'b1, 4'b0110, 64'd1, '0, 1'b0);
    step(1'b1, 4'b0110, 64'd1, {1'b1, 64'd0}, 1'b0);
    step(1'b1, 4'b0101, 64'd1, {1'b1, 64'd3}, 1'b0);
    drain();

    // Reset asserted mid-cycle with three entries stored.
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, 64'd1, (N+2)'(300 + i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'b0001, 64'd1, {1'b1, 64'h55}, 1'b0);
    chk("post_rst_head", bus.out_y, {1'b1, 64'h55});
    drain();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      logic [N:0] b;
      logic [N+1:0] y;
      op = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15));
      b  = ($urandom_range(0, 3) == 0) ? '0 : {$urandom, $urandom};
      y  = ($urandom_range(0, 7) == 0) ? '0 : rand_y();
      step(1'($urandom_range(0, 1)), op, b, y, 1'($urandom_range(0, 1)));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
